// File: rtl/seq_detect_scheduler.sv
// seq_detect_scheduler
//   Time-shares one external serial "1011" sequence detector between two
//   word requesters. A granted word is serialised MSB-first onto the
//   detector input after a one-cycle detector clear. Detector hits that are
//   attributed to the word's bits are counted, and the count is returned on
//   a valid/ready result port. Requesters are arbitrated round-robin.
//
// Ports
//   clock             rising-edge clock
//   reset             asynchronous active-low reset
//   req0_valid/data   requester 0 word offer
//   req0_ready        requester 0 word accepted this cycle (combinational)
//   req1_valid/data   requester 1 word offer
//   req1_ready        requester 1 word accepted this cycle (combinational)
//   det_clear         one-cycle pulse returning the detector to its start state
//   seq_out           serial bit to the detector (registered)
//   det_in            detector output
//   res_valid/ready   result handshake
//   res_count         detections attributed to the word (saturating)
//   res_hit           res_count != 0
//   res_src           requester index the result belongs to
//   busy              scheduler is not idle
module seq_detect_scheduler #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned CNT_W   = 4,
    parameter int unsigned DET_LAT = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_data,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_data,
    output logic             req1_ready,
    output logic             det_clear,
    output logic             seq_out,
    input  logic             det_in,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [CNT_W-1:0] res_count,
    output logic             res_hit,
    output logic             res_src,
    output logic             busy
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        SHIFT,
        DRAIN,
        DONE
    } state_e;

    // Phase counter indexes shift cycles (0..WIDTH-1) and drain cycles
    // (0..DET_LAT-1).
    localparam int unsigned PH_W = $clog2(WIDTH + DET_LAT + 1);

    localparam logic [PH_W-1:0]  PH_LAT      = PH_W'(DET_LAT);
    localparam logic [PH_W-1:0]  PH_LAST_BIT = PH_W'(WIDTH - 1);
    localparam logic [PH_W-1:0]  PH_LAST_DRN = PH_W'(DET_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_e             state_q;
    logic               rr_q;
    logic [WIDTH-1:0]   data_q;
    logic               src_q;
    logic [PH_W-1:0]    phase_q;
    logic [CNT_W-1:0]   count_q;
    logic               seq_out_q;
    logic               det_clear_q;
    logic               res_valid_q;
    logic [CNT_W-1:0]   res_count_q;
    logic               res_hit_q;
    logic               res_src_q;
    logic               busy_q;

    logic               idle;
    logic               grant1;
    logic               xfer;
    logic [CNT_W-1:0]   count_d;

    // Grant: a lone valid wins; with both valid the rr pointer decides.
    always_comb begin
        idle       = (state_q == IDLE);
        grant1     = req1_valid && (!req0_valid || rr_q);
        req1_ready = idle && grant1;
        req0_ready = idle && req0_valid && !grant1;
        xfer       = req0_ready || req1_ready;
    end

    // Saturating accumulate of the current detector sample.
    always_comb begin
        count_d = count_q;
        if (det_in && (count_q != CNT_MAX)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            data_q      <= '0;
            src_q       <= 1'b0;
            phase_q     <= '0;
            count_q     <= '0;
            seq_out_q   <= 1'b0;
            det_clear_q <= 1'b0;
            res_valid_q <= 1'b0;
            res_count_q <= '0;
            res_hit_q   <= 1'b0;
            res_src_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            det_clear_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (xfer) begin
                        data_q      <= req1_ready ? req1_data : req0_data;
                        src_q       <= req1_ready;
                        rr_q        <= ~req1_ready;
                        det_clear_q <= 1'b1;
                        seq_out_q   <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= CLEAR;
                    end
                end
                CLEAR: begin
                    // data_q doubles as the shift register: its MSB is
                    // always the next bit to drive.
                    count_q   <= '0;
                    phase_q   <= '0;
                    seq_out_q <= data_q[WIDTH-1];
                    data_q    <= data_q << 1;
                    state_q   <= SHIFT;
                end
                SHIFT: begin
                    // The first DET_LAT samples still belong to the
                    // previous (cleared) detector history.
                    if (phase_q >= PH_LAT) begin
                        count_q <= count_d;
                    end
                    if (phase_q == PH_LAST_BIT) begin
                        seq_out_q <= 1'b0;
                        phase_q   <= '0;
                        state_q   <= DRAIN;
                    end else begin
                        seq_out_q <= data_q[WIDTH-1];
                        data_q    <= data_q << 1;
                        phase_q   <= phase_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (phase_q == PH_LAST_DRN) begin
                        res_count_q <= count_d;
                        res_hit_q   <= (count_d != '0);
                        res_src_q   <= src_q;
                        res_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        count_q <= count_d;
                        phase_q <= phase_q + 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign seq_out   = seq_out_q;
    assign det_clear = det_clear_q;
    assign res_valid = res_valid_q;
    assign res_count = res_count_q;
    assign res_hit   = res_hit_q;
    assign res_src   = res_src_q;
    assign busy      = busy_q;

endmodule

// File: doc/seq_detect_scheduler.md
Name: seq_detect_scheduler

Overview:
- Shares one serial 1011 sequence detector between two word requesters.
- Arbitrates round-robin and clears the detector before each word.
- Serializes the granted word MSB-first onto the detector's `sequence_in`, and counts detector hits attributed to that word.
- Returns the count to the requester through a valid/ready result port.

Parameters:
- WIDTH, 8, bits per request word (≥2).
- CNT_W, 4, result count width; must hold WIDTH (clog2(WIDTH+1)).
- DET_LAT, 1, cycles from a bit driven on seq_out to its effect visible on det_in (Moore detector = 1); range 1..4.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has a word.
- req0_data  in  WIDTH  requester 0 word.
- req0_ready  out  1  requester 0 word accepted this cycle (valid&ready).
- req1_valid  in  1  requester 1 has a word.
- req1_data  in  WIDTH  requester 1 word.
- req1_ready  out  1  requester 1 word accepted this cycle (valid&ready).
- det_clear  out  1  one-cycle pulse returning the detector to its initial state.
- seq_out  out  1  serial bit to the detector `sequence_in` (registered).
- det_in  in  1  detector `detector_out`.
- res_valid  out  1  result available.
- res_ready  in  1  result consumer accepts.
- res_count  out  CNT_W  detections attributed to the word.
- res_hit  out  1  res_count != 0.
- res_src  out  1  requester index of the result.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; rr pointer=0.
  - seq_out, det_clear, res_valid, res_count, res_hit, res_src, busy = 0.
  - Any partial word is discarded and no result is produced.
- FSM states: IDLE, CLEAR, SHIFT, DRAIN, DONE.
- IDLE:
  - reqN_ready is combinational and high only for the granted side.
  - Grant rule: only one valid → grant it; both valid → grant the rr pointer side.
  - On transfer: latch data and src, set rr pointer = other side, go to CLEAR.
  - No valid → stay in IDLE.
- CLEAR (1 cycle):
  - det_clear=1, seq_out=0, det_in ignored, count cleared to 0.
  - Next state SHIFT.
- SHIFT (exactly WIDTH cycles):
  - Shift cycle k (k=0..WIDTH-1) drives seq_out = data[WIDTH-1-k].
  - det_in in cycle k+DET_LAT is attributed to bit k; counted if 1.
  - Counting is active in shift cycles DET_LAT..WIDTH-1.
- DRAIN (DET_LAT cycles):
  - seq_out=0; det_in counted, completing exactly WIDTH attributed samples.
  - Next state DONE.
- DONE:
  - res_valid=1; res_count/res_hit/res_src are stable while valid.
  - Hold until res_ready=1; on res_valid&res_ready, res_valid=0 next cycle and return to IDLE.
  - res_ready high on DONE entry → result lasts one cycle.
- Count saturates at 2^CNT_W-1; it never wraps.
- Request inputs are ignored outside IDLE; reqN_ready=0 outside IDLE.
- req valid dropped before grant is legal and causes no grant.
- Minimum per-word occupancy: 1 (IDLE) + 1 (CLEAR) + WIDTH + DET_LAT + 1 (DONE). WIDTH=8, DET_LAT=1 → 12 cycles.
- Back-to-back: both requesters continuously valid → grants alternate 0,1,0,1 starting at 0 after reset.
- Reset asserted mid-SHIFT/DRAIN/DONE:
  - Immediately IDLE, with all outputs at their reset values.
  - After release, the first grant follows rr pointer=0.

Test Plan:
- Single word: req0 8'b1011_0000, res_ready=1, bench detector model (1011 Moore) → grant cycle after valid; det_clear one cycle; seq_out 1,0,1,1,0,0,0,0; res_valid 11 cycles after grant with res_count=1, res_hit=1, res_src=0.
- No match: req1 8'b0000_0000 → res_count=0, res_hit=0, res_src=1, no det_in pulses counted.
- Double match and backpressure: req0 8'b1011_1011, res_ready=0 for 5 cycles → res_valid held 5+ cycles with res_count=2 stable; no new grant until res_ready=1.
- Arbitration: req0 and req1 both valid continuously (0x0B, 0xB0) → grant order 0,1,0,1; reqN_ready one cycle per grant; results alternate src 0,1 with counts 1,1.
- Clear isolation: word 8'b0000_0101 then 8'b1100_0000 → second count 0 (no carry-over of "101" suffix); det_clear pulses before each word.
- Reset mid-SHIFT (cycle 4 of word): reset low 2 cycles → busy=0 and seq_out=0 immediately, no res_valid; next word grants req0 and completes normally.
